// File: rtl/rgb_pwm_fader.sv
// Onboard RGB LED output stage: accepts a target colour, fades each channel
// linearly toward it one code per fade tick, and drives active-low PWM pins.
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 24000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3*PWM_BITS-1:0] cmd_rgb,
  output logic                  busy,
  output logic [3*PWM_BITS-1:0] level_rgb,
  output logic [2:0]            led
);

  localparam int W  = PWM_BITS;
  localparam int TW = $clog2(STEP_DIV);
  localparam logic [W-1:0]  PWM_LAST  = W'((2**W) - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);

  typedef enum logic {S_IDLE, S_FADE} state_t;

  state_t          r_state, w_state_nxt;
  logic [3*W-1:0]  r_level, r_target, w_level_nxt;
  logic [W-1:0]    r_pwm_cnt;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
  logic [2:0]      r_led, w_led_nxt, w_lit;
  logic            w_accept, w_tick;

  // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and nothing is queued while fading.
  always_comb begin
    w_accept    = cmd_valid && (r_state == S_IDLE);
    w_tick      = (r_state == S_FADE) && (r_tick_cnt == TICK_LAST);
    w_level_nxt = r_level;
    w_lit       = '0;
    // Channel slices: 0 = B, 1 = G, 2 = R
    for (int i = 0; i < 3; i++) begin
      w_lit[i] = (r_pwm_cnt < r_level[i*W +: W]);
      if (w_tick) begin
        if (r_level[i*W +: W] < r_target[i*W +: W])
          w_level_nxt[i*W +: W] = r_level[i*W +: W] + W'(1);
        else if (r_level[i*W +: W] > r_target[i*W +: W])
          w_level_nxt[i*W +: W] = r_level[i*W +: W] - W'(1);
      end
    end
    // Pin order on the board is {G, R, B}
    w_led_nxt = ~{w_lit[1], w_lit[2], w_lit[0]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_rgb != r_level))
          w_state_nxt = S_FADE;
      end
      S_FADE: begin
        w_tick_nxt = w_tick ? '0 : r_tick_cnt + TW'(1);
        if (w_tick && (w_level_nxt == r_target))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_level    <= '0;
      r_target   <= '0;
      r_pwm_cnt  <= '0;
      r_tick_cnt <= '0;
      r_led      <= 3'b111;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_led      <= w_led_nxt;
      r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + W'(1);
      if (w_accept)
        r_target <= cmd_rgb;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_FADE);
  assign level_rgb = r_level;
  assign led       = r_led;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: a level-trajectory scoreboard checked on
// every level change, plus directed reset, timing, duty and handshake checks.
module tb_rgb_pwm_fader;

  localparam int SD = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_rgb = '0;
  logic        cmd_ready;
  logic        busy;
  logic [23:0] level_rgb;
  logic [2:0]  led;

  logic [23:0] exp_q[$];
  logic [23:0] m_level = '0;
  logic [23:0] prev_lvl = '0;
  logic [23:0] exp_lvl;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  rgb_pwm_fader #(.PWM_BITS(8), .STEP_DIV(SD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rgb   (cmd_rgb),
    .busy      (busy),
    .level_rgb (level_rgb),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected level after every fade tick, walking each channel by one code
  task automatic push_traj(input logic [23:0] tgt);
    logic [7:0] c, t;
    while (m_level != tgt) begin
      for (int i = 0; i < 3; i++) begin
        c = m_level[i*8 +: 8];
        t = tgt[i*8 +: 8];
        if (c < t) c = c + 8'd1;
        else if (c > t) c = c - 8'd1;
        m_level[i*8 +: 8] = c;
      end
      exp_q.push_back(m_level);
    end
  endtask

  // Called anywhere; returns at negedge+1 after the accepting edge
  task automatic send_cmd(input logic [23:0] rgb, output int waits);
    waits = 0;
    @(negedge sys_clk); #1;
    cmd_valid = 1'b1;
    cmd_rgb   = rgb;
    while (!cmd_ready && waits < 3000) begin
      @(negedge sys_clk); #1;
      waits++;
    end
    chk("accept_timeout", cmd_ready, 1);
    ref_cyc = cyc + 1;
    push_traj(rgb);
    @(negedge sys_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 3000) begin
      @(negedge sys_clk); #1;
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Scoreboard monitor: every level change pops one expected value
  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      prev_lvl = level_rgb;
    end else if (level_rgb !== prev_lvl) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", level_rgb, prev_lvl);
      end else begin
        exp_lvl = exp_q.pop_front();
        chk("level_step", level_rgb, exp_lvl);
      end
      chk("step_interval", cyc - ref_cyc, SD);
      ref_cyc  = cyc;
      prev_lvl = level_rgb;
    end
  end

  initial begin
    int k, w, bad, lit_r, lit_g, lit_b;

    // Reset values
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_led", led, 3'b111);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level_rgb, 0);
    @(negedge sys_clk); #1 sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (led !== 3'b111) bad++;
    end
    chk("idle_led_dark", bad, 0);

    // Ramp up red
    send_cmd(24'hFF0000, w);
    chk("ramp_busy_rise", busy, 1);
    chk("ramp_ready_low", cmd_ready, 0);
    wait_idle(k);
    chk("ramp_duration", k, 1020);
    repeat (3) @(negedge sys_clk);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (led !== 3'b101) bad++;
    end
    chk("red_full_led", bad, 0);

    // Mixed directions
    send_cmd(24'hFF0080, w);
    wait_idle(k);
    chk("to_ff0080_duration", k, 512);
    send_cmd(24'h001080, w);
    repeat (16 * SD + 2) @(negedge sys_clk);
    #1;
    chk("mixed_g_done", level_rgb, 24'hEF1080);
    chk("mixed_still_busy", busy, 1);
    wait_idle(k);
    chk("mixed_duration", k, 1020 - 16 * SD - 2);
    chk("mixed_final", level_rgb, 24'h001080);

    // Duty at {40,00,C0}
    send_cmd(24'h4000C0, w);
    wait_idle(k);
    chk("duty_setup_duration", k, 64 * SD);
    repeat (3) @(negedge sys_clk);
    lit_r = 0; lit_g = 0; lit_b = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      if (!led[1]) lit_r++;
      if (!led[2]) lit_g++;
      if (!led[0]) lit_b++;
    end
    chk("duty_r", lit_r, 64);
    chk("duty_g", lit_g, 0);
    chk("duty_b", lit_b, 192);

    // Held command during FADE is taken the cycle ready returns
    send_cmd(24'h101010, w);
    send_cmd(24'h203040, w);
    chk("held_cmd_wait", w, 703);
    chk("held_busy", busy, 1);
    wait_idle(k);
    chk("held_final", level_rgb, 24'h203040);

    // Command equal to current level
    send_cmd(24'h203040, w);
    chk("equal_accept_wait", w, 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    chk("equal_no_busy", bad, 0);
    chk("equal_level", level_rgb, 24'h203040);

    // Reset in the middle of a 0 -> FF ramp
    send_cmd(24'h000000, w);
    wait_idle(k);
    send_cmd(24'hFFFFFF, w);
    k = 0;
    while (level_rgb[23:16] != 8'd50 && k < 3000) begin
      @(negedge sys_clk); #1;
      k++;
    end
    chk("tick50_reached", level_rgb, 24'h323232);
    sys_rst_n = 1'b0;
    exp_q.delete();
    m_level = '0;
    #1;
    chk("midrst_level", level_rgb, 0);
    chk("midrst_led", led, 3'b111);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge sys_clk); #1 sys_rst_n = 1'b1;
    send_cmd(24'h050607, w);
    chk("post_rst_busy", busy, 1);
    wait_idle(k);
    chk("post_rst_duration", k, 7 * SD);
    chk("post_rst_level", level_rgb, 24'h050607);

    repeat (5) @(negedge sys_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
Downstream LED output stage for the Tang Nano onboard RGB LED. It accepts a 24-bit target colour over a valid/ready handshake and ramps each channel's brightness linearly toward that target, one code per fade tick. It drives the three active-low LED pins with per-channel PWM. Upstream pattern or sequencer logic issues colour commands; the block owns the physical led pins.

Parameters:
PWM_BITS, 8, channel level / PWM resolution; PWM period = 2^PWM_BITS-1 clocks (255 at default).
STEP_DIV, 24000, sys_clk cycles per fade tick (1 ms at 24 MHz); legal range >= 2.

Ports:
sys_clk  input  1  system clock (24 MHz on board)
sys_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  colour command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_rgb  input  3*PWM_BITS  target colour {R,G,B}; R in MSBs
busy  output  1  fade in progress (high in FADE)
level_rgb  output  3*PWM_BITS  current channel levels {R,G,B}, for debug/verification
led  output  3  active-low LED drive: led[0]=B, led[1]=R, led[2]=G (0 = lit)

Behaviour:
- Reset (sys_rst_n low, asynchronous): state=IDLE, levels=0, target=0, pwm_cnt=0, tick_cnt=0, cmd_ready=1, busy=0, led=3'b111 (all off). Reset mid-fade aborts immediately to these values; no partial command survives.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-2, then wraps to 0 (255-clock period). Channel lit when pwm_cnt < level. Level 0 means never lit; level 255 means always lit. led is registered: led[i] = ~(pwm_cnt < level_i), sampled one cycle after pwm_cnt/level change.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_rgb is latched into target on that edge. cmd_valid while cmd_ready=0 is ignored; there is no queueing, and upstream holds cmd_valid until ready.
- FSM IDLE: cmd_ready=1, busy=0.
  - Accept with target == current levels: stay IDLE; there is no visible change.
  - Accept with any channel different: go to FADE and clear tick_cnt to 0.
- FSM FADE: cmd_ready=0, busy=1.
  - tick_cnt counts 0..STEP_DIV-1 and wraps; a fade tick fires on the cycle tick_cnt==STEP_DIV-1.
  - On each tick, every channel with level<target increments by 1, and every channel with level>target decrements by 1. Equal channels hold.
  - Channels move independently and may finish at different ticks.
  - On the tick where all three channels reach target, go to IDLE; cmd_ready=1 from the next cycle.
  - First step lands STEP_DIV clocks after acceptance. Total fade time = max|target-level| * STEP_DIV clocks.
- Arithmetic: levels are unsigned PWM_BITS wide. Steps are exactly +/-1 and never overshoot, wrap, or saturate past target.
- level_rgb mirrors the level registers directly, with no extra latency.
- Outside FADE, tick_cnt holds 0.

Test Plan:
- Reset check (STEP_DIV=4): assert sys_rst_n=0 -> led=3'b111, cmd_ready=1, busy=0, level_rgb=0. Release, then run 600 clocks -> led stays 3'b111.
- Ramp-up (STEP_DIV=4): send cmd_rgb=24'hFF0000 -> busy rises the next cycle. R steps 0->255 at 4-clock intervals; busy falls after 1020 clocks. Then led[1]=0 constantly, led[0]=led[2]=1.
- Mixed directions: from {FF,00,80} send {00,10,80} -> R decrements and G increments; G finishes after 16 ticks, and R alone continues. B is untouched. Return to IDLE after 255 ticks.
- Duty check (idle, level {40,00,C0}): over one 255-clock period, count lit cycles -> R=64, G=0, B=192.
- Handshake: hold cmd_valid with a new colour during FADE -> not accepted until cmd_ready=1, then latched in that cycle. A command equal to the current level -> busy never rises.
- Reset mid-fade: at tick 50 of a 0->FF ramp, pulse sys_rst_n low -> levels=0, led=3'b111, state=IDLE. After release, a new command is accepted normally.
